// File: rtl/i2c_cs_pkg.sv
// Shared constants for the 0x44 RGB colour-sensor I2C responder: register map,
// FSM encoding, default identity and the snapshot bundle type.
package i2c_cs_pkg;

    localparam logic [6:0] CS_DEFAULT_ADDRESS = 7'h44;
    localparam logic [7:0] CS_DEFAULT_ID      = 8'h7D;

    localparam logic [7:0] CS_DEVICE_ID_REG = 8'h00;
    localparam logic [7:0] CS_CONFIG_REG1   = 8'h01;
    localparam logic [7:0] CS_CONFIG_REG2   = 8'h02;
    localparam logic [7:0] CS_CONFIG_REG3   = 8'h03;
    localparam logic [7:0] CS_G_LOW         = 8'h09;
    localparam logic [7:0] CS_G_HIGH        = 8'h0A;
    localparam logic [7:0] CS_R_LOW         = 8'h0B;
    localparam logic [7:0] CS_R_HIGH        = 8'h0C;
    localparam logic [7:0] CS_B_LOW         = 8'h0D;
    localparam logic [7:0] CS_B_HIGH        = 8'h0E;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WR_BYTE   = 3'd3;
    localparam logic [2:0] ST_WR_ACK    = 3'd4;
    localparam logic [2:0] ST_RD_BYTE   = 3'd5;
    localparam logic [2:0] ST_RD_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    typedef struct packed {
        logic [15:0] green;
        logic [15:0] red;
        logic [15:0] blue;
    } cs_levels_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the raw SCL/SDA pins into the clock domain and derives the bus events
// the responder FSM works from.
module i2c_line_sync (
    input  logic clock_25mhz,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Reset to the idle-bus level so leaving reset never fakes an edge or START.
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign sda_level = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_prev;
    assign scl_fall  = ~scl_sync[1] & scl_prev;
    assign start_det = scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];

endmodule

// File: rtl/i2c_color_sensor_responder.sv
// I2C target emulating the RGB colour sensor: ID, three config registers and
// snapshotted 16-bit G/R/B levels, served over an open-drain SDA.
module i2c_color_sensor_responder
    import i2c_cs_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDRESS = CS_DEFAULT_ADDRESS,
    parameter logic [7:0] DEVICE_ID      = CS_DEFAULT_ID
) (
    input  logic        clock_25mhz,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] red_level,
    input  logic [15:0] green_level,
    input  logic [15:0] blue_level,
    input  logic        sample_load,
    output logic [7:0]  config1,
    output logic [7:0]  config2,
    output logic [7:0]  config3,
    output logic        write_strobe,
    output logic        busy
);

    logic       sda_level;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    logic [2:0] state;
    logic [3:0] bit_count;
    logic [7:0] shift_reg;
    logic [7:0] pointer;
    logic       pointer_phase;
    logic       ack_bit;
    logic [7:0] read_data;

    cs_levels_t incoming;
    cs_levels_t snapshot;
    cs_levels_t captured;
    logic       pending;

    i2c_line_sync u_line_sync (
        .clock_25mhz (clock_25mhz),
        .reset       (reset),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .sda_level   (sda_level),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_det   (start_det),
        .stop_det    (stop_det)
    );

    assign incoming = '{green: green_level, red: red_level, blue: blue_level};

    always_comb begin
        read_data = 8'h00;
        case (pointer)
            CS_DEVICE_ID_REG: read_data = DEVICE_ID;
            CS_CONFIG_REG1:   read_data = config1;
            CS_CONFIG_REG2:   read_data = config2;
            CS_CONFIG_REG3:   read_data = config3;
            CS_G_LOW:         read_data = snapshot.green[7:0];
            CS_G_HIGH:        read_data = snapshot.green[15:8];
            CS_R_LOW:         read_data = snapshot.red[7:0];
            CS_R_HIGH:        read_data = snapshot.red[15:8];
            CS_B_LOW:         read_data = snapshot.blue[7:0];
            CS_B_HIGH:        read_data = snapshot.blue[15:8];
            default:          read_data = 8'h00;
        endcase
    end

    // Levels strobed mid-transaction are held back so a burst read stays coherent.
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            snapshot <= '0;
            captured <= '0;
            pending  <= 1'b0;
        end else if (sample_load) begin
            if (!busy || stop_det) begin
                snapshot <= incoming;
                pending  <= 1'b0;
            end else begin
                captured <= incoming;
                pending  <= 1'b1;
            end
        end else if (stop_det && pending) begin
            snapshot <= captured;
            pending  <= 1'b0;
        end
    end

    // SDA only ever moves on a detected SCL fall, so it is stable while SCL is high.
    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_count     <= 4'd0;
            shift_reg     <= 8'h00;
            pointer       <= 8'h00;
            pointer_phase <= 1'b0;
            ack_bit       <= 1'b1;
            sda_oe        <= 1'b0;
            busy          <= 1'b0;
            write_strobe  <= 1'b0;
            config1       <= 8'h00;
            config2       <= 8'h00;
            config3       <= 8'h00;
        end else begin
            write_strobe <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state     <= ST_ADDR;
                bit_count <= 4'd0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_level};
                            bit_count <= bit_count + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_count == 4'd8) begin
                                if (shift_reg[7:1] == DEVICE_ADDRESS) begin
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                    state  <= ST_ADDR_ACK;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= ST_WAIT_STOP;
                                end
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_count <= 4'd0;
                            if (shift_reg[0]) begin
                                shift_reg <= read_data;
                                sda_oe    <= ~read_data[7];
                                state     <= ST_RD_BYTE;
                            end else begin
                                sda_oe        <= 1'b0;
                                pointer_phase <= 1'b1;
                                state         <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_level};
                            bit_count <= bit_count + 4'd1;
                        end else if (scl_fall && bit_count == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= ST_WR_ACK;
                            if (pointer_phase) begin
                                pointer       <= shift_reg;
                                pointer_phase <= 1'b0;
                            end else begin
                                case (pointer)
                                    CS_CONFIG_REG1: config1 <= shift_reg;
                                    CS_CONFIG_REG2: config2 <= shift_reg;
                                    CS_CONFIG_REG3: config3 <= shift_reg;
                                    default: ;
                                endcase
                                write_strobe <= 1'b1;
                                pointer      <= pointer + 8'd1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe    <= 1'b0;
                            bit_count <= 4'd0;
                            state     <= ST_WR_BYTE;
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_count <= bit_count + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_count == 4'd8) begin
                                sda_oe  <= 1'b0;
                                pointer <= pointer + 8'd1;
                                state   <= ST_RD_ACK;
                            end else begin
                                sda_oe    <= ~shift_reg[6];
                                shift_reg <= {shift_reg[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            ack_bit <= sda_level;
                        end else if (scl_fall) begin
                            if (!ack_bit) begin
                                shift_reg <= read_data;
                                sda_oe    <= ~read_data[7];
                                bit_count <= 4'd0;
                                state     <= ST_RD_BYTE;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_color_sensor_responder.sv
// Bench acting as I2C initiator against the colour-sensor responder, with a
// transaction-level register-map model supplying every expected value.
module tb_i2c_color_sensor_responder;

    localparam int T = 6;

    logic        clock_25mhz = 1'b0;
    logic        reset       = 1'b1;
    logic        scl_drv     = 1'b1;
    logic        sda_drv     = 1'b1;
    logic        sample_load = 1'b0;
    logic [15:0] red_level   = 16'h0000;
    logic [15:0] green_level = 16'h0000;
    logic [15:0] blue_level  = 16'h0000;
    logic        sda_oe;
    logic        busy;
    logic        write_strobe;
    logic [7:0]  config1;
    logic [7:0]  config2;
    logic [7:0]  config3;
    logic        sda_bus;

    assign sda_bus = sda_drv & ~sda_oe;

    always #20 clock_25mhz = ~clock_25mhz;

    i2c_color_sensor_responder dut (
        .clock_25mhz  (clock_25mhz),
        .reset        (reset),
        .scl_in       (scl_drv),
        .sda_in       (sda_bus),
        .sda_oe       (sda_oe),
        .red_level    (red_level),
        .green_level  (green_level),
        .blue_level   (blue_level),
        .sample_load  (sample_load),
        .config1      (config1),
        .config2      (config2),
        .config3      (config3),
        .write_strobe (write_strobe),
        .busy         (busy)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Register-map model, advanced once per transferred byte
    logic [7:0]  m_cfg [0:3];
    logic [15:0] m_g, m_r, m_b, c_g, c_r, c_b;
    bit          m_pending;
    bit          m_busy;
    logic [7:0]  m_ptr;
    int          m_strobes   = 0;
    int          dut_strobes = 0;
    bit          bus_idle    = 1'b0;

    logic [7:0]  wbuf [0:7];
    logic [7:0]  rbuf [0:7];
    logic [7:0]  exp_burst [0:5];
    logic [15:0] mid_r, mid_g, mid_b;

    function automatic logic [7:0] model_read(input logic [7:0] p);
        case (p)
            8'h00: return 8'h7D;
            8'h01, 8'h02, 8'h03: return m_cfg[p[1:0]];
            8'h09: return m_g[7:0];
            8'h0A: return m_g[15:8];
            8'h0B: return m_r[7:0];
            8'h0C: return m_r[15:8];
            8'h0D: return m_b[7:0];
            8'h0E: return m_b[15:8];
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
        m_g = 16'h0; m_r = 16'h0; m_b = 16'h0;
        m_pending = 1'b0;
        m_busy    = 1'b0;
        m_ptr     = 8'h00;
    endtask

    task automatic model_stop();
        m_busy = 1'b0;
        if (m_pending) begin
            m_g = c_g; m_r = c_r; m_b = c_b;
            m_pending = 1'b0;
        end
    endtask

    always @(negedge clock_25mhz) begin
        if (bus_idle && !reset) begin
            check_output("idle_config1", 16'(config1), 16'(m_cfg[1]));
            check_output("idle_config2", 16'(config2), 16'(m_cfg[2]));
            check_output("idle_config3", 16'(config3), 16'(m_cfg[3]));
            check_output("idle_busy", 16'(busy), 16'd0);
            check_output("idle_sda_oe", 16'(sda_oe), 16'd0);
        end
    end

    always @(negedge clock_25mhz) begin
        if (write_strobe === 1'b1) dut_strobes++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock_25mhz);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clk(T);
        scl_drv = 1'b1; wait_clk(T);
        sda_drv = 1'b0; wait_clk(T);
        scl_drv = 1'b0; wait_clk(T);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(T);
        scl_drv = 1'b1; wait_clk(T);
        sda_drv = 1'b1; wait_clk(T);
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b;    wait_clk(T);
        scl_drv = 1'b1; wait_clk(T);
        scl_drv = 1'b0; wait_clk(T);
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_clk(T);
        scl_drv = 1'b1; wait_clk(T / 2);
        b = sda_bus;    wait_clk(T - T / 2);
        scl_drv = 1'b0; wait_clk(T);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    task automatic apply_stimulus(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        @(negedge clock_25mhz);
        red_level = r; green_level = g; blue_level = b;
        sample_load = 1'b1;
        @(negedge clock_25mhz);
        sample_load = 1'b0;
        if (m_busy) begin
            c_r = r; c_g = g; c_b = b;
            m_pending = 1'b1;
        end else begin
            m_r = r; m_g = g; m_b = b;
        end
    endtask

    task automatic do_write(input logic [6:0] addr, input int n);
        logic ack;
        bit   hit;
        bus_idle = 1'b0;
        hit = (addr == 7'h44);
        i2c_start();
        write_byte({addr, 1'b0}, ack);
        check_output("wr_addr_ack", 16'(ack), hit ? 16'd0 : 16'd1);
        check_output("wr_busy_after_addr", 16'(busy), hit ? 16'd1 : 16'd0);
        if (hit) begin
            m_busy = 1'b1;
            for (int i = 0; i < n; i++) begin
                write_byte(wbuf[i], ack);
                check_output("wr_data_ack", 16'(ack), 16'd0);
                if (i == 0) m_ptr = wbuf[0];
                else begin
                    if (m_ptr >= 8'd1 && m_ptr <= 8'd3) m_cfg[m_ptr[1:0]] = wbuf[i];
                    m_strobes++;
                    m_ptr++;
                end
            end
        end
        i2c_stop();
        wait_clk(8);
        model_stop();
        check_output("write_strobe_count", 16'(dut_strobes), 16'(m_strobes));
        bus_idle = 1'b1;
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n, input bit mid);
        logic       ack;
        logic [7:0] d;
        logic [7:0] e;
        bus_idle = 1'b0;
        i2c_start();
        write_byte(8'h88, ack);
        check_output("rd_waddr_ack", 16'(ack), 16'd0);
        m_busy = 1'b1;
        write_byte(ptr, ack);
        check_output("rd_ptr_ack", 16'(ack), 16'd0);
        m_ptr = ptr;
        i2c_start();
        write_byte(8'h89, ack);
        check_output("rd_raddr_ack", 16'(ack), 16'd0);
        check_output("rd_busy_after_restart", 16'(busy), 16'd1);
        for (int i = 0; i < n; i++) begin
            if (mid && i == 1) apply_stimulus(mid_r, mid_g, mid_b);
            read_byte(d, (i == n - 1));
            e = model_read(m_ptr);
            m_ptr++;
            check_output("rd_byte", 16'(d), 16'(e));
            rbuf[i] = d;
        end
        check_output("rd_release_after_nack", 16'(sda_oe), 16'd0);
        i2c_stop();
        wait_clk(8);
        model_stop();
        bus_idle = 1'b1;
    endtask

    function automatic logic [7:0] pick_ptr();
        case ($urandom_range(0, 2))
            0:       return 8'($urandom_range(0, 3));
            1:       return 8'($urandom_range(9, 14));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #(40 * 95000);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ack;
        model_reset();
        reset = 1'b1;
        wait_clk(4);
        check_output("reset_sda_oe", 16'(sda_oe), 16'd0);
        check_output("reset_busy", 16'(busy), 16'd0);
        check_output("reset_write_strobe", 16'(write_strobe), 16'd0);
        check_output("reset_config1", 16'(config1), 16'd0);
        check_output("reset_config2", 16'(config2), 16'd0);
        check_output("reset_config3", 16'(config3), 16'd0);
        red_level = 16'hDEAD; green_level = 16'hBEEF; blue_level = 16'hF00D;
        reset = 1'b0;
        wait_clk(4);
        bus_idle = 1'b1;

        $display("[TB] data registers start cleared");
        do_read(8'h0D, 2, 1'b0);
        check_output("lit_b_after_reset", {rbuf[1], rbuf[0]}, 16'h0000);

        $display("[TB] write config1");
        wbuf[0] = 8'h01; wbuf[1] = 8'h05;
        do_write(7'h44, 2);
        check_output("lit_config1", 16'(config1), 16'h0005);
        check_output("lit_strobe_one", 16'(dut_strobes), 16'd1);

        $display("[TB] device id read");
        do_read(8'h00, 1, 1'b0);
        check_output("lit_device_id", 16'(rbuf[0]), 16'h007D);

        $display("[TB] burst read of sample");
        apply_stimulus(16'h1234, 16'hABCD, 16'h00FF);
        do_read(8'h09, 6, 1'b0);
        exp_burst = '{8'hCD, 8'hAB, 8'h34, 8'h12, 8'hFF, 8'h00};
        for (int i = 0; i < 6; i++) check_output("lit_burst", 16'(rbuf[i]), 16'(exp_burst[i]));

        $display("[TB] wrong address");
        wbuf[0] = 8'h01; wbuf[1] = 8'hAA;
        do_write(7'h45, 2);
        check_output("lit_config1_kept", 16'(config1), 16'h0005);

        $display("[TB] strobe during burst");
        mid_r = 16'h5555; mid_g = 16'h6666; mid_b = 16'h7777;
        do_read(8'h09, 6, 1'b1);
        check_output("lit_coherent_r", {rbuf[3], rbuf[2]}, 16'h1234);
        check_output("lit_coherent_b", {rbuf[5], rbuf[4]}, 16'h00FF);
        do_read(8'h09, 6, 1'b0);
        check_output("lit_new_g", {rbuf[1], rbuf[0]}, 16'h6666);
        check_output("lit_new_r", {rbuf[3], rbuf[2]}, 16'h5555);
        check_output("lit_new_b", {rbuf[5], rbuf[4]}, 16'h7777);

        $display("[TB] pointer wrap");
        do_read(8'hFE, 3, 1'b0);
        check_output("lit_wrap_id", 16'(rbuf[2]), 16'h007D);

        wbuf[0] = 8'h02; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
        do_write(7'h44, 3);
        check_output("lit_config3", 16'(config3), 16'h00C3);

        $display("[TB] reset while driving a zero bit");
        bus_idle = 1'b0;
        i2c_start();
        write_byte(8'h88, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h89, ack);
        check_output("drive_zero_bit", 16'(sda_oe), 16'd1);
        @(negedge clock_25mhz);
        reset = 1'b1;
        @(negedge clock_25mhz);
        check_output("reset_abort_sda_oe", 16'(sda_oe), 16'd0);
        check_output("reset_abort_busy", 16'(busy), 16'd0);
        check_output("reset_abort_config1", 16'(config1), 16'd0);
        check_output("reset_abort_config2", 16'(config2), 16'd0);
        check_output("reset_abort_config3", 16'(config3), 16'd0);
        reset = 1'b0;
        model_reset();
        i2c_stop();
        wait_clk(8);
        bus_idle = 1'b1;
        wbuf[0] = 8'h01; wbuf[1] = 8'h3C;
        do_write(7'h44, 2);
        check_output("lit_after_reset_write", 16'(config1), 16'h003C);

        $display("[TB] randomized transactions");
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    int n;
                    n = int'($urandom_range(2, 4));
                    wbuf[0] = pick_ptr();
                    for (int i = 1; i < n; i++) wbuf[i] = 8'($urandom);
                    do_write(7'h44, n);
                end
                1: begin
                    mid_r = 16'($urandom); mid_g = 16'($urandom); mid_b = 16'($urandom);
                    do_read(pick_ptr(), int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
                end
                2: begin
                    wbuf[0] = 8'h01; wbuf[1] = 8'($urandom);
                    do_write(7'h44 ^ 7'($urandom_range(1, 127)), 2);
                end
                default: begin
                    apply_stimulus(16'($urandom), 16'($urandom), 16'($urandom));
                    wait_clk(2);
                end
            endcase
        end
        do_read(8'h09, 6, 1'b0);

        bus_idle = 1'b0;
        wait_clk(2);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
